// File: rtl/mem_write_checker.sv
// Self-check monitor on the data-memory write port: matches writes against an expected table.
// Define MEMCHK_TRACE_EN to build the 8-entry write trace buffer.
module mem_write_checker #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int NUM_CHECKS     = 2,
    parameter int ORDERED        = 1,
    parameter int TIMEOUT_CYCLES = 0,
    parameter int CNT_W          = 32,
    localparam int MC_W          = $clog2(NUM_CHECKS + 1)
) (
    input  logic                           sysclk,
    input  logic                           reset,
    input  logic                           enable,
    input  logic                           mem_write,
    input  logic [ADDR_W-1:0]              mem_addr,
    input  logic [DATA_W-1:0]              mem_wdata,
    input  logic [NUM_CHECKS*ADDR_W-1:0]   exp_addr,
    input  logic [NUM_CHECKS*DATA_W-1:0]   exp_data,
    input  logic [ADDR_W-1:0]              ign_addr,
    input  logic [ADDR_W-1:0]              ign_mask,
    output logic                           busy,
    output logic                           success,
    output logic                           fail,
    output logic [1:0]                     fail_code,
    output logic [ADDR_W-1:0]              fail_addr,
    output logic [DATA_W-1:0]              fail_data,
    output logic [MC_W-1:0]                match_count,
    output logic [CNT_W-1:0]               cycle_count,
    input  logic [2:0]                     trace_sel,
    output logic [ADDR_W-1:0]              trace_addr,
    output logic [DATA_W-1:0]              trace_data
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_t;

    localparam logic [1:0]       CODE_DATA    = 2'd1;
    localparam logic [1:0]       CODE_ADDR    = 2'd2;
    localparam logic [1:0]       CODE_TIMEOUT = 2'd3;
    localparam logic [MC_W-1:0]  MC_LAST      = MC_W'(NUM_CHECKS - 1);
    localparam logic [CNT_W-1:0] TO_LAST      = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX      = '1;

    state_t                r_state;
    logic                  r_enable_d;
    logic [NUM_CHECKS-1:0] r_hit;
    logic [MC_W-1:0]       r_match_count;
    logic [CNT_W-1:0]      r_cycle_count;
    logic [1:0]            r_fail_code;
    logic [ADDR_W-1:0]     r_fail_addr;
    logic [DATA_W-1:0]     r_fail_data;

    logic                  w_arm;
    logic                  w_ign;
    logic                  w_match;
    logic                  w_bad_data;
    logic                  w_dup;
    logic                  w_timeout;
    logic                  w_record;
    logic [NUM_CHECKS-1:0] w_addr_eq;
    logic [NUM_CHECKS-1:0] w_data_eq;
    logic [NUM_CHECKS-1:0] w_pend;
    logic [NUM_CHECKS-1:0] w_set;

    genvar gi;

    // Rising edges that arrive while running are deliberately dropped.
    assign w_arm     = enable & ~r_enable_d & (r_state != S_RUN);
    assign w_ign     = ((mem_addr ^ ign_addr) & ign_mask) == '0;
    assign w_pend    = ~r_hit;
    assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_cycle_count == TO_LAST);

    generate
        for (gi = 0; gi < NUM_CHECKS; gi++) begin : g_cmp
            assign w_addr_eq[gi] = mem_addr  == exp_addr[gi*ADDR_W +: ADDR_W];
            assign w_data_eq[gi] = mem_wdata == exp_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    generate
        if (ORDERED != 0) begin : g_ordered
            logic [NUM_CHECKS-1:0] w_cur;
            for (gi = 0; gi < NUM_CHECKS; gi++) begin : g_cur
                assign w_cur[gi] = (r_match_count == MC_W'(gi));
            end
            assign w_set      = w_cur & w_pend & w_addr_eq & w_data_eq;
            assign w_bad_data = |(w_cur & w_addr_eq & ~w_data_eq);
            assign w_dup      = 1'b0;
        end else begin : g_unordered
            logic [NUM_CHECKS-1:0] w_full;
            assign w_full     = w_pend & w_addr_eq & w_data_eq;
            // Isolate the lowest-index pending entry that fully matches.
            assign w_set      = w_full & (~w_full + NUM_CHECKS'(1));
            assign w_bad_data = ~(|w_full) & (|(w_pend & w_addr_eq));
            assign w_dup      = |(r_hit & w_addr_eq & w_data_eq);
        end
    endgenerate

    assign w_match  = |w_set;
    assign w_record = (r_state == S_RUN) & mem_write & (w_match | w_bad_data | ~(w_dup | w_ign));

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_enable_d    <= 1'b0;
            r_hit         <= '0;
            r_match_count <= '0;
            r_cycle_count <= '0;
            r_fail_code   <= '0;
            r_fail_addr   <= '0;
            r_fail_data   <= '0;
        end else begin
            r_enable_d <= enable;
            case (r_state)
                S_RUN: begin
                    if (r_cycle_count != CNT_MAX) begin
                        r_cycle_count <= r_cycle_count + CNT_W'(1);
                    end
                    // The write is classified first; the timeout only fires if the write did not end the run.
                    if (mem_write && w_match) begin
                        r_hit         <= r_hit | w_set;
                        r_match_count <= r_match_count + MC_W'(1);
                        if (r_match_count == MC_LAST) begin
                            r_state <= S_PASS;
                        end else if (w_timeout) begin
                            r_state     <= S_FAIL;
                            r_fail_code <= CODE_TIMEOUT;
                        end
                    end else if (mem_write && w_bad_data) begin
                        r_state     <= S_FAIL;
                        r_fail_code <= CODE_DATA;
                        r_fail_addr <= mem_addr;
                        r_fail_data <= mem_wdata;
                    end else if (mem_write && !w_dup && !w_ign) begin
                        r_state     <= S_FAIL;
                        r_fail_code <= CODE_ADDR;
                        r_fail_addr <= mem_addr;
                        r_fail_data <= mem_wdata;
                    end else if (w_timeout) begin
                        r_state     <= S_FAIL;
                        r_fail_code <= CODE_TIMEOUT;
                        r_fail_addr <= '0;
                        r_fail_data <= '0;
                    end
                end
                default: begin
                    if (w_arm) begin
                        r_state       <= S_RUN;
                        r_hit         <= '0;
                        r_match_count <= '0;
                        r_cycle_count <= '0;
                        r_fail_code   <= '0;
                        r_fail_addr   <= '0;
                        r_fail_data   <= '0;
                    end
                end
            endcase
        end
    end

    assign busy        = (r_state == S_RUN);
    assign success     = (r_state == S_PASS);
    assign fail        = (r_state == S_FAIL);
    assign fail_code   = r_fail_code;
    assign fail_addr   = r_fail_addr;
    assign fail_data   = r_fail_data;
    assign match_count = r_match_count;
    assign cycle_count = r_cycle_count;

`ifdef MEMCHK_TRACE_EN
    logic [ADDR_W-1:0] r_tr_addr [8];
    logic [DATA_W-1:0] r_tr_data [8];
    logic [2:0]        r_tr_ptr;
    logic [2:0]        w_tr_rd;

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            r_tr_ptr <= '0;
            for (int i = 0; i < 8; i++) begin
                r_tr_addr[i] <= '0;
                r_tr_data[i] <= '0;
            end
        end else if (w_arm) begin
            r_tr_ptr <= '0;
            for (int i = 0; i < 8; i++) begin
                r_tr_addr[i] <= '0;
                r_tr_data[i] <= '0;
            end
        end else if (w_record) begin
            r_tr_addr[r_tr_ptr] <= mem_addr;
            r_tr_data[r_tr_ptr] <= mem_wdata;
            r_tr_ptr            <= r_tr_ptr + 3'd1;
        end
    end

    // Pointer addresses the next free slot, so the newest entry sits one behind it.
    assign w_tr_rd    = r_tr_ptr - 3'd1 - trace_sel;
    assign trace_addr = r_tr_addr[w_tr_rd];
    assign trace_data = r_tr_data[w_tr_rd];
`else
    logic w_unused_trace;
    assign w_unused_trace = ^{trace_sel, w_record};
    assign trace_addr     = '0;
    assign trace_data     = '0;
`endif

endmodule

// File: tb/tb_mem_write_checker.sv
// Scoreboard bench for mem_write_checker: instance A ordered with timeout 10, instance B unordered.
module tb_mem_write_checker;
    logic sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    logic        reset = 1'b1;
    logic        en_a = 1'b0, wr_a = 1'b0, en_b = 1'b0, wr_b = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic [63:0] exp_addr = {32'd100, 32'd96};
    logic [63:0] exp_data = {32'd25, 32'd7};
    logic [31:0] ign_addr = 32'h0000_1000;
    logic [31:0] ign_mask = 32'hFFFF_F000;
    logic [2:0]  trace_sel = 3'd0;

    logic        busy_a, success_a, fail_a, busy_b, success_b, fail_b;
    logic [1:0]  code_a, code_b, mc_a, mc_b;
    logic [31:0] faddr_a, fdata_a, faddr_b, fdata_b, cc_a, cc_b;
    logic [31:0] taddr_a, tdata_a, taddr_b, tdata_b;

    int n_checks = 0;
    int n_fail   = 0;

    mem_write_checker #(.NUM_CHECKS(2), .ORDERED(1), .TIMEOUT_CYCLES(10)) u_dut_a (
        .sysclk(sysclk), .reset(reset), .enable(en_a), .mem_write(wr_a),
        .mem_addr(addr), .mem_wdata(wdata), .exp_addr(exp_addr), .exp_data(exp_data),
        .ign_addr(ign_addr), .ign_mask(ign_mask), .busy(busy_a), .success(success_a),
        .fail(fail_a), .fail_code(code_a), .fail_addr(faddr_a), .fail_data(fdata_a),
        .match_count(mc_a), .cycle_count(cc_a), .trace_sel(trace_sel),
        .trace_addr(taddr_a), .trace_data(tdata_a)
    );

    mem_write_checker #(.NUM_CHECKS(2), .ORDERED(0), .TIMEOUT_CYCLES(0)) u_dut_b (
        .sysclk(sysclk), .reset(reset), .enable(en_b), .mem_write(wr_b),
        .mem_addr(addr), .mem_wdata(wdata), .exp_addr(exp_addr), .exp_data(exp_data),
        .ign_addr(ign_addr), .ign_mask(ign_mask), .busy(busy_b), .success(success_b),
        .fail(fail_b), .fail_code(code_b), .fail_addr(faddr_b), .fail_data(fdata_b),
        .match_count(mc_b), .cycle_count(cc_b), .trace_sel(trace_sel),
        .trace_addr(taddr_b), .trace_data(tdata_b)
    );

    typedef struct {
        string       tag;
        bit          use_b;
        bit          busy;
        bit          success;
        bit          fail;
        logic [1:0]  code;
        logic [31:0] faddr;
        logic [31:0] fdata;
        logic [1:0]  mc;
    } exp_t;

    exp_t sb[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input string tag, input bit b, input bit bs, input bit sc, input bit fl,
                        input logic [1:0] code, input logic [31:0] fa, input logic [31:0] fd,
                        input logic [1:0] mc);
        exp_t e;
        e.tag = tag; e.use_b = b; e.busy = bs; e.success = sc; e.fail = fl;
        e.code = code; e.faddr = fa; e.fdata = fd; e.mc = mc;
        sb.push_back(e);
    endtask

    task automatic exp_run(input string tag, input bit b, input logic [1:0] mc);
        push(tag, b, 1'b1, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0, mc);
    endtask

    task automatic exp_pass(input string tag, input bit b);
        push(tag, b, 1'b0, 1'b1, 1'b0, 2'd0, 32'd0, 32'd0, 2'd2);
    endtask

    task automatic exp_fail(input string tag, input bit b, input logic [1:0] code,
                            input logic [31:0] fa, input logic [31:0] fd, input logic [1:0] mc);
        push(tag, b, 1'b0, 1'b0, 1'b1, code, fa, fd, mc);
    endtask

    // One clock, then pop the oldest expectation and compare it to the selected instance.
    task automatic step();
        exp_t        e;
        logic        o_busy, o_succ, o_fail;
        logic [1:0]  o_code, o_mc;
        logic [31:0] o_fa, o_fd;
        @(posedge sysclk);
        #1;
        check_eq("sb_nonempty", 64'(sb.size() != 0), 64'd1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        if (e.use_b) begin
            o_busy = busy_b; o_succ = success_b; o_fail = fail_b;
            o_code = code_b; o_fa = faddr_b; o_fd = fdata_b; o_mc = mc_b;
        end else begin
            o_busy = busy_a; o_succ = success_a; o_fail = fail_a;
            o_code = code_a; o_fa = faddr_a; o_fd = fdata_a; o_mc = mc_a;
        end
        $display("txn %-14s inst=%s busy=%0b success=%0b fail=%0b code=%0d addr=%0h data=%0h mc=%0d",
                 e.tag, e.use_b ? "B" : "A", o_busy, o_succ, o_fail, o_code, o_fa, o_fd, o_mc);
        check_eq({e.tag, ".busy"},    64'(o_busy), 64'(e.busy));
        check_eq({e.tag, ".success"}, 64'(o_succ), 64'(e.success));
        check_eq({e.tag, ".fail"},    64'(o_fail), 64'(e.fail));
        check_eq({e.tag, ".code"},    64'(o_code), 64'(e.code));
        check_eq({e.tag, ".faddr"},   64'(o_fa),   64'(e.faddr));
        check_eq({e.tag, ".fdata"},   64'(o_fd),   64'(e.fdata));
        check_eq({e.tag, ".mc"},      64'(o_mc),   64'(e.mc));
    endtask

    task automatic arm(input string tag, input bit b);
        if (b) en_b = 1'b1; else en_a = 1'b1;
        exp_run(tag, b, 2'd0);
        step();
        en_a = 1'b0;
        en_b = 1'b0;
    endtask

    task automatic write(input bit b, input logic [31:0] a, input logic [31:0] d);
        addr = a;
        wdata = d;
        if (b) wr_b = 1'b1; else wr_a = 1'b1;
        step();
        wr_a = 1'b0;
        wr_b = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got still running expected finished");
        $fatal(1, "time limit");
    end

    initial begin
        #12;
        check_eq("rst.busy",    64'(busy_a),    64'd0);
        check_eq("rst.success", 64'(success_a), 64'd0);
        check_eq("rst.fail",    64'(fail_a),    64'd0);
        check_eq("rst.code",    64'(code_a),    64'd0);
        check_eq("rst.mc",      64'(mc_a),      64'd0);
        check_eq("rst.cc",      64'(cc_a),      64'd0);
        check_eq("rst.busy_b",  64'(busy_b),    64'd0);
        @(posedge sysclk);
        #1;
        reset = 1'b0;

        // Ordered pass, enable held high throughout: no re-arm after PASS.
        en_a = 1'b1;
        exp_run("pass_arm", 0, 2'd0);       step();
        exp_run("pass_w0", 0, 2'd1);        write(0, 32'd96, 32'd7);
        exp_pass("pass_w1", 0);             write(0, 32'd100, 32'd25);
        exp_pass("pass_hold", 0);           step();
        en_a = 1'b0;
        exp_pass("pass_sticky", 0);         step();

        exp_run("mis_arm", 0, 2'd0);        arm("mis_arm", 0);
        void'(sb.pop_back());
        exp_fail("mis_w", 0, 2'd1, 32'd96, 32'd8, 2'd0);   write(0, 32'd96, 32'd8);
        exp_fail("mis_sticky", 0, 2'd1, 32'd96, 32'd8, 2'd0); step();

        arm("ign_arm", 0);
        exp_run("ign_w", 0, 2'd0);          write(0, 32'h1234, 32'd5);
        exp_fail("unexp_w", 0, 2'd2, 32'd200, 32'd1, 2'd0); write(0, 32'd200, 32'd1);

        arm("ord_arm", 0);
        exp_fail("ord_w", 0, 2'd2, 32'd100, 32'd25, 2'd0); write(0, 32'd100, 32'd25);

        // Timeout after exactly 10 RUN cycles.
        arm("to_arm", 0);
        check_eq("to_arm.cc", 64'(cc_a), 64'd0);
        for (int i = 0; i < 9; i++) begin
            exp_run("to_idle", 0, 2'd0);
            step();
        end
        check_eq("to_cc9", 64'(cc_a), 64'd9);
        exp_fail("to_fire", 0, 2'd3, 32'd0, 32'd0, 2'd0);   step();

        // Completing match on the timeout cycle wins.
        arm("tpass_arm", 0);
        for (int i = 0; i < 8; i++) begin
            exp_run("tpass_idle", 0, 2'd0);
            step();
        end
        exp_run("tpass_w0", 0, 2'd1);       write(0, 32'd96, 32'd7);
        exp_pass("tpass_w1", 0);            write(0, 32'd100, 32'd25);

        // Unexpected write on the timeout cycle reports code 2.
        arm("tfail_arm", 0);
        for (int i = 0; i < 9; i++) begin
            exp_run("tfail_idle", 0, 2'd0);
            step();
        end
        exp_fail("tfail_w", 0, 2'd2, 32'd200, 32'd1, 2'd0); write(0, 32'd200, 32'd1);

`ifdef MEMCHK_TRACE_EN
        arm("tr_arm", 0);
        exp_run("tr_w0", 0, 2'd1);          write(0, 32'd96, 32'd7);
        exp_run("tr_w1", 0, 2'd1);          write(0, 32'h1004, 32'd3);
        exp_fail("tr_w2", 0, 2'd1, 32'd100, 32'd9, 2'd1); write(0, 32'd100, 32'd9);
        trace_sel = 3'd0; #1;
        check_eq("tr0.addr", 64'(taddr_a), 64'd100);
        check_eq("tr0.data", 64'(tdata_a), 64'd9);
        trace_sel = 3'd1; #1;
        check_eq("tr1.addr", 64'(taddr_a), 64'd96);
        check_eq("tr1.data", 64'(tdata_a), 64'd7);
        trace_sel = 3'd2; #1;
        check_eq("tr2.addr", 64'(taddr_a), 64'd0);
        trace_sel = 3'd0;
`else
        check_eq("tr_off.addr", 64'(taddr_a), 64'd0);
        check_eq("tr_off.data", 64'(tdata_a), 64'd0);
`endif

        // Re-arm from FAIL, then asynchronous reset mid-RUN.
        arm("rearm", 0);
        check_eq("rearm.cc", 64'(cc_a), 64'd0);
        exp_run("rearm_w", 0, 2'd1);        write(0, 32'd96, 32'd7);
        reset = 1'b1;
        #1;
        check_eq("arst.busy",  64'(busy_a),  64'd0);
        check_eq("arst.succ",  64'(success_a), 64'd0);
        check_eq("arst.fail",  64'(fail_a),  64'd0);
        check_eq("arst.code",  64'(code_a),  64'd0);
        check_eq("arst.mc",    64'(mc_a),    64'd0);
        check_eq("arst.cc",    64'(cc_a),    64'd0);
        #2;
        reset = 1'b0;

        // Unordered instance.
        arm("u_arm", 1);
        exp_run("u_w0", 1, 2'd1);           write(1, 32'd100, 32'd25);
        exp_run("u_dup", 1, 2'd1);          write(1, 32'd100, 32'd25);
        exp_pass("u_w1", 1);                write(1, 32'd96, 32'd7);
        arm("u_arm2", 1);
        exp_fail("u_mis", 1, 2'd1, 32'd96, 32'd9, 2'd0);    write(1, 32'd96, 32'd9);
        arm("u_arm3", 1);
        exp_run("u_hit", 1, 2'd1);          write(1, 32'd96, 32'd7);
        exp_fail("u_rehit", 1, 2'd2, 32'd96, 32'd8, 2'd1);  write(1, 32'd96, 32'd8);

        check_eq("sb_drained", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
